l2_stride_prefetcher: RTL and testbench
=======================================

Name: l2_stride_prefetcher

Overview:
- PC-indexed stride prefetcher sitting directly upstream of the L2 cache's prefetch port.
- Consumes the D-side access stream (D-prefetch tap: pipeline address, PC, valid) and learns a per-PC stride with a confidence counter.
- Queues line-aligned candidate addresses and issues them one at a time over the L2 prefetch handshake (req/addrOK/complete).
- Throttles itself on L2 demand-miss feedback.

Parameters:
TBL_LOG, 4, log2 of stride-table entries (direct-mapped, indexed by pc[TBL_LOG+1:2])
Q_LOG, 2, log2 of candidate FIFO depth
LINE_OFF, 5, log2 of L2 line size in bytes (8 words = 32 B)
CONF_TH, 2, confidence (2-bit saturating) needed to generate a candidate

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-high (asserted = 1), name kept for codebase uniformity
dcache_pref_addr  in  32  D-side access address
dcache_pref_pc  in  32  PC of that access
dcache_pref_valid  in  1  access valid this cycle
req_pref_l2cache  out  1  prefetch request
type_pref_l2cache  out  1  0-instruction, 1-data; tied 1
addr_pref_l2cache  out  32  line-aligned prefetch address
addrOK_l2cache_pref  in  1  L2 accepted address
complete_l2cache_pref  in  1  L2 finished prefetch
hit_l2cache_pref  in  1  prefetch hit in L2 (no memory fill)
miss_l2cache_pref  in  1  L1 demand miss while prefetch in progress
pref_issued_cnt  out  16  wrapping count of accepted prefetches
pref_drop_cnt  out  16  wrapping count of candidates dropped (full, dedup, page cross, flush)

Behaviour:
- Reset: all table valid bits 0; FIFO empty; FSM IDLE; req 0; addr_pref 0; both counters 0; type_pref 1.
- Table entry fields: valid, tag (pc[31:TBL_LOG+2]), last_addr[31:0], stride[31:0] signed, conf[1:0].
- Training, one cycle per valid access:
  - Tag miss or invalid: allocate with last_addr=addr, stride=0, conf=0; no candidate.
  - Tag hit: d = addr - last_addr (32-bit two's complement, wraps).
    - d == stride: conf = sat_inc(conf).
    - Otherwise: conf = sat_dec(conf); stride = d only if old conf == 0.
    - last_addr = addr.
- Candidate generation, same cycle as training, computed from the updated entry:
  - Generate if conf_new >= CONF_TH and stride != 0.
  - cand = (addr + stride) with low LINE_OFF bits cleared.
  - Drop (pref_drop_cnt+1) if any of:
    - cand[31:12] != addr[31:12] (page cross);
    - cand line equals addr's line;
    - cand equals the most recently pushed candidate (dedup register, cleared on reset/flush);
    - FIFO full with no pop this cycle.
  - Otherwise push the following cycle. Registered, so push latency = 1 cycle after the access.
- FIFO:
  - Depth 2^Q_LOG, pointers wrap modulo depth.
  - Push and pop in the same cycle are legal when full: count unchanged.
- Issue FSM:
  - IDLE: FIFO non-empty -> pop head into addr_pref, req=1, go REQ.
  - REQ: hold req and addr stable until addrOK. On addrOK, req=0, pref_issued_cnt+1, go WAIT.
  - WAIT: on complete -> IDLE. complete in the same cycle as addrOK -> IDLE directly. hit_l2cache_pref is informational only.
- Throttle:
  - miss_l2cache_pref=1 in any state flushes the FIFO and clears the dedup register.
  - Each flushed entry increments pref_drop_cnt; a flush of N entries adds N in one cycle.
  - An in-flight REQ/WAIT request is never cancelled.
  - A push arriving in the flush cycle is also dropped.
- Access and handshake paths are independent; training never stalls; the block never back-pressures the D-side.
- Synchronous reset mid-REQ drops req the next edge with no handshake completion required; L2 must tolerate a withdrawn request at reset.
- Counters wrap at 0xFFFF -> 0x0000.

Test Plan:
- Stride learn: pc=0x1C000100, addrs 0x1000, 0x1040, 0x1080, 0x10C0 (stride 0x40) -> candidate 0x1100 after the 4th access (conf reaches 2). req asserted with addr 0x1100; on 3rd access conf=1 so no request.
- Handshake: hold addrOK low for 5 cycles -> req and addr stay constant. addrOK pulse -> req low next cycle, pref_issued_cnt=1. complete after 10 cycles -> IDLE, next head issued.
- Page cross: stride 0x40 with trained last access 0x1FC0 -> cand 0x2000 dropped, pref_drop_cnt+1, no req.
- Dedup and full: two PCs sharing stream 0x3000+0x20k, L2 stalls addrOK -> duplicate lines dropped. With Q_LOG=2, the 5th distinct candidate while in REQ is dropped; push+pop in the same cycle when full keeps count=4.
- Throttle: 3 entries queued, miss_l2cache_pref pulse in WAIT -> FIFO empty, pref_drop_cnt+=3, current request still completes, no further req.
- Reset: rstn=1 during REQ -> req=0, counters 0, table invalid. Repeating a previously trained stream needs full relearning (first candidate on the 4th access).

Source files
------------

// File: rtl/l2_stride_prefetcher.sv
// PC-indexed stride prefetcher feeding the L2 prefetch port.
// Ports: D-side tap (addr/pc/valid), L2 prefetch handshake, issue/drop counters.
module l2_stride_prefetcher #(
  parameter int TBL_LOG  = 4,
  parameter int Q_LOG    = 2,
  parameter int LINE_OFF = 5,
  parameter int CONF_TH  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dcache_pref_addr,
  input  logic [31:0] dcache_pref_pc,
  input  logic        dcache_pref_valid,
  output logic        req_pref_l2cache,
  output logic        type_pref_l2cache,
  output logic [31:0] addr_pref_l2cache,
  input  logic        addrOK_l2cache_pref,
  input  logic        complete_l2cache_pref,
  input  logic        hit_l2cache_pref,
  input  logic        miss_l2cache_pref,
  output logic [15:0] pref_issued_cnt,
  output logic [15:0] pref_drop_cnt
);

  localparam int N = 1 << TBL_LOG;
  localparam int DEPTH = 1 << Q_LOG;
  localparam int TW = 30 - TBL_LOG;
  localparam logic [31:0] LMASK =
    ~((32'd1 << LINE_OFF) - 32'd1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT
  } st_t;

  logic [N-1:0]    t_v;
  logic [TW-1:0]   t_tag [N];
  logic [31:0]     t_last [N];
  logic [31:0]     t_stride [N];
  logic [1:0]      t_conf [N];

  logic [TBL_LOG-1:0] idx;
  logic [TW-1:0]   tag;
  logic            hit;
  logic [31:0]     e_last, e_stride, d;
  logic [1:0]      e_conf, conf_new;
  logic [31:0]     stride_new, cand;
  logic            gen, bad;

  assign type_pref_l2cache = 1'b1;

  assign idx = dcache_pref_pc[TBL_LOG+1:2];
  assign tag = dcache_pref_pc[31:TBL_LOG+2];
  assign hit = t_v[idx] && (t_tag[idx] == tag);
  assign e_last = t_last[idx];
  assign e_stride = t_stride[idx];
  assign e_conf = t_conf[idx];
  assign d = dcache_pref_addr - e_last;

  // Stride is only re-learned once confidence has drained to zero.
  always_comb begin
    conf_new = e_conf;
    stride_new = e_stride;
    if (d == e_stride) begin
      if (e_conf != 2'd3) conf_new = e_conf + 2'd1;
    end else begin
      if (e_conf != 2'd0) conf_new = e_conf - 2'd1;
      else stride_new = d;
    end
  end

  assign cand = (dcache_pref_addr + stride_new) & LMASK;
  assign gen = dcache_pref_valid && hit &&
               (conf_new >= 2'(CONF_TH)) &&
               (stride_new != 32'd0);
  assign bad =
    (cand[31:12] != dcache_pref_addr[31:12]) ||
    (cand[31:LINE_OFF] ==
     dcache_pref_addr[31:LINE_OFF]);

  always_ff @(posedge clk) begin
    if (rstn) t_v <= '0;
    else if (dcache_pref_valid) t_v[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (dcache_pref_valid) begin
      t_tag[idx] <= tag;
      t_last[idx] <= dcache_pref_addr;
      t_stride[idx] <= hit ? stride_new : 32'd0;
      t_conf[idx] <= hit ? conf_new : 2'd0;
    end
  end

  // Candidate stage: filtering and FIFO push happen one cycle later.
  logic        c_v, c_bad;
  logic [31:0] c_addr;

  always_ff @(posedge clk) begin
    if (rstn) begin
      c_v <= 1'b0;
      c_bad <= 1'b0;
      c_addr <= '0;
    end else begin
      c_v <= gen;
      c_bad <= bad;
      c_addr <= cand;
    end
  end

  logic [31:0]      mem [DEPTH];
  logic [Q_LOG-1:0] wp, rp;
  logic [Q_LOG:0]   cnt;
  logic             dd_v;
  logic [31:0]      dd_addr;
  logic             flush, pop, full, dup;
  logic             push, c_drop;
  logic [15:0]      drop_inc;
  st_t              state;

  assign flush = miss_l2cache_pref;
  assign pop = (state == IDLE) && (cnt != '0) && !flush;
  assign full = cnt == (Q_LOG+1)'(DEPTH);
  assign dup = dd_v && (c_addr == dd_addr);
  assign push = c_v && !flush && !c_bad && !dup &&
                (!full || pop);
  assign c_drop = c_v && !push;
  assign drop_inc = 16'(c_drop) +
                    (flush ? 16'(cnt) : 16'd0);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= c_addr;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      dd_v <= 1'b0;
      dd_addr <= '0;
      pref_drop_cnt <= '0;
    end else begin
      pref_drop_cnt <= pref_drop_cnt + drop_inc;
      if (flush) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        dd_v <= 1'b0;
      end else begin
        if (push) begin
          wp <= wp + 1'b1;
          dd_v <= 1'b1;
          dd_addr <= c_addr;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (Q_LOG+1)'(push) -
               (Q_LOG+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
      req_pref_l2cache <= 1'b0;
      addr_pref_l2cache <= '0;
      pref_issued_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (pop) begin
          addr_pref_l2cache <= mem[rp];
          req_pref_l2cache <= 1'b1;
          state <= REQ;
        end
        REQ: if (addrOK_l2cache_pref) begin
          req_pref_l2cache <= 1'b0;
          pref_issued_cnt <= pref_issued_cnt + 16'd1;
          state <= complete_l2cache_pref ? IDLE : WAIT;
        end
        WAIT: if (complete_l2cache_pref) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{hit_l2cache_pref, dcache_pref_pc[1:0]};

endmodule

// File: tb/tb_l2_stride_prefetcher.sv
// Self-checking bench for l2_stride_prefetcher.
// Directed scenarios plus random traffic against a queue-based model.
module tb_l2_stride_prefetcher;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] a_addr = '0, a_pc = '0;
  logic        a_v = 1'b0;
  logic        req, typ;
  logic [31:0] paddr;
  logic        ok = 1'b0, cpl = 1'b0;
  logic        hit = 1'b0, miss = 1'b0;
  logic [15:0] iss, drp;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_stride_prefetcher dut (
    .clk(clk),
    .rstn(rstn),
    .dcache_pref_addr(a_addr),
    .dcache_pref_pc(a_pc),
    .dcache_pref_valid(a_v),
    .req_pref_l2cache(req),
    .type_pref_l2cache(typ),
    .addr_pref_l2cache(paddr),
    .addrOK_l2cache_pref(ok),
    .complete_l2cache_pref(cpl),
    .hit_l2cache_pref(hit),
    .miss_l2cache_pref(miss),
    .pref_issued_cnt(iss),
    .pref_drop_cnt(drp)
  );

  // Reference model: table as arrays, FIFO as a queue.
  bit          mv [16];
  logic [31:0] mtag [16];
  logic [31:0] mlast [16];
  logic [31:0] mstr [16];
  int          mconf [16];
  bit          m_cv, m_bad;
  logic [31:0] m_cand;
  logic [31:0] q [$];
  bit          dd_v;
  logic [31:0] dd;
  int          m_st;
  bit          m_req;
  logic [31:0] m_addr;
  logic [15:0] m_iss, m_drop;

  task automatic model_step();
    int sz, ix;
    bit pop;
    logic [31:0] dlt, ns, c;
    int nc;
    if (rstn) begin
      foreach (mv[i]) mv[i] = 0;
      m_cv = 0; q.delete(); dd_v = 0;
      m_st = 0; m_req = 0; m_addr = 0;
      m_iss = 0; m_drop = 0;
      return;
    end
    sz = q.size();
    pop = (m_st == 0) && (sz > 0) && !miss;
    if (m_st == 0) begin
      if (pop) begin
        m_addr = q.pop_front();
        m_req = 1; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (ok) begin
        m_req = 0; m_iss++;
        m_st = cpl ? 0 : 2;
      end
    end else if (cpl) m_st = 0;
    if (miss) begin
      m_drop += 16'(sz) + 16'(m_cv);
      q.delete(); dd_v = 0;
    end else if (m_cv) begin
      if (m_bad || (dd_v && m_cand == dd) ||
          (sz == 4 && !pop))
        m_drop++;
      else begin
        q.push_back(m_cand);
        dd_v = 1; dd = m_cand;
      end
    end
    m_cv = 0;
    if (a_v) begin
      ix = int'(a_pc[5:2]);
      if (!mv[ix] || mtag[ix] != (a_pc >> 6)) begin
        mv[ix] = 1; mtag[ix] = a_pc >> 6;
        mlast[ix] = a_addr; mstr[ix] = 0;
        mconf[ix] = 0;
      end else begin
        dlt = a_addr - mlast[ix];
        ns = mstr[ix]; nc = mconf[ix];
        if (dlt == mstr[ix]) nc = (nc < 3) ? nc + 1 : 3;
        else if (nc > 0) nc = nc - 1;
        else ns = dlt;
        mstr[ix] = ns; mconf[ix] = nc;
        mlast[ix] = a_addr;
        if (nc >= 2 && ns != 0) begin
          c = (a_addr + ns) & ~32'd31;
          m_cv = 1; m_cand = c;
          m_bad = ((c >> 12) != (a_addr >> 12)) ||
                  ((c >> 5) == (a_addr >> 5));
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("req", 32'(req), 32'(m_req));
    chk("addr", paddr, m_addr);
    chk("type", 32'(typ), 32'd1);
    chk("issued", 32'(iss), 32'(m_iss));
    chk("drop", 32'(drp), 32'(m_drop));
  endtask

  task automatic acc(logic [31:0] pc, logic [31:0] ad);
    a_pc = pc; a_addr = ad; a_v = 1'b1;
    cyc();
    a_v = 1'b0;
  endtask

  task automatic wait_req(string tag);
    int n;
    n = 0;
    while (!req && n < 10) begin
      cyc(); n++;
    end
    chk(tag, 32'(req), 32'd1);
  endtask

  logic [31:0] spc [4];
  logic [31:0] sad [4];
  logic [31:0] sst [4];
  logic [31:0] pcs [6];
  logic [31:0] strs [6];

  initial begin
    pcs = '{32'h1C000100, 32'h1C000140, 32'h1C000104,
            32'h1C000208, 32'h1C00030C, 32'h1C000500};
    strs = '{32'h20, 32'h40, -32'sd64, 32'h80, 32'h4,
             32'h100};
    cyc();
    cyc();
    rstn = 1'b0;
    cyc();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_iss", 32'(iss), 32'd0);
    chk("rst_drop", 32'(drp), 32'd0);

    // stride learn
    acc(32'h1C000100, 32'h1000);
    acc(32'h1C000100, 32'h1040);
    acc(32'h1C000100, 32'h1080);
    cyc(); cyc(); cyc();
    chk("no_req_conf1", 32'(req), 32'd0);
    acc(32'h1C000100, 32'h10C0);
    wait_req("learn_req");
    chk("learn_addr", paddr, 32'h1100);

    // handshake hold
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_req", 32'(req), 32'd1);
      chk("hold_addr", paddr, 32'h1100);
    end
    ok = 1'b1;
    cyc();
    ok = 1'b0;
    chk("ok_req", 32'(req), 32'd0);
    chk("ok_iss", 32'(iss), 32'd1);
    for (int i = 0; i < 10; i++) cyc();
    cpl = 1'b1;
    cyc();
    cpl = 1'b0;

    // page cross
    acc(32'h1C000204, 32'h1F00);
    acc(32'h1C000204, 32'h1F40);
    acc(32'h1C000204, 32'h1F80);
    acc(32'h1C000204, 32'h1FC0);
    for (int i = 0; i < 4; i++) cyc();
    chk("pg_drop", 32'(drp), 32'd1);
    chk("pg_noreq", 32'(req), 32'd0);

    // reset in REQ, then full relearn
    acc(32'h1C000100, 32'h1100);
    wait_req("pre_rst_req");
    rstn = 1'b1;
    cyc();
    rstn = 1'b0;
    chk("mid_rst_req", 32'(req), 32'd0);
    chk("mid_rst_iss", 32'(iss), 32'd0);
    chk("mid_rst_drop", 32'(drp), 32'd0);
    acc(32'h1C000100, 32'h1000);
    acc(32'h1C000100, 32'h1040);
    acc(32'h1C000100, 32'h1080);
    cyc(); cyc(); cyc();
    chk("relearn_noreq", 32'(req), 32'd0);
    acc(32'h1C000100, 32'h10C0);
    wait_req("relearn_req");
    chk("relearn_addr", paddr, 32'h1100);

    // random traffic
    for (int k = 0; k < 20000; k++) begin
      if (k % 300 == 0) begin
        for (int s = 0; s < 4; s++) begin
          spc[s] = pcs[$urandom_range(5)];
          sad[s] = ($urandom & 32'hFFFF_FFFC);
          if ($urandom_range(3) == 0)
            sad[s] = {sad[s][31:12], 12'hF00};
          sst[s] = strs[$urandom_range(5)];
        end
        if ($urandom_range(1) == 0) begin
          sad[1] = sad[0]; sst[1] = sst[0];
        end
      end
      a_v = ($urandom_range(9) < 6);
      if (a_v) begin
        int s;
        s = $urandom_range(3);
        a_pc = spc[s];
        a_addr = sad[s];
        sad[s] = sad[s] + sst[s];
        if ($urandom_range(40) == 0)
          a_addr = $urandom;
      end
      ok = ($urandom_range(9) < 3);
      cpl = ($urandom_range(9) < 2);
      hit = $urandom_range(1) == 1;
      miss = ($urandom_range(99) < 3);
      rstn = ($urandom_range(2999) == 0);
      cyc();
    end
    rstn = 1'b0; a_v = 1'b0; miss = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
